// File: rtl/input_command_queue.sv
// Turns per-frame NES button codes into one-shot game commands with DAS/ARR
// auto-repeat on DOWN/LEFT/RIGHT, buffered in a small valid/ready FIFO.
module input_command_queue #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_WINDOW = 1000000,
  parameter int unsigned DAS_FRAMES  = 10,
  parameter int unsigned ARR_FRAMES  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   button_code,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [2:0]                   cmd_code,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow
);

  localparam int unsigned GW = $clog2(HOLD_WINDOW + 1);
  localparam int unsigned DW = $clog2(DAS_FRAMES + 1);
  localparam int unsigned AW = $clog2(ARR_FRAMES + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [GW-1:0] HOLD_MAX = GW'(HOLD_WINDOW);
  localparam logic [DW-1:0] DAS_LAST = DW'(DAS_FRAMES - 1);
  localparam logic [DW-1:0] DAS_DONE = DW'(DAS_FRAMES);
  localparam logic [AW-1:0] ARR_LAST = AW'(ARR_FRAMES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [3:0]    code_q, prev_q;
  logic [3:0]    last_code_q, last_code_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [DW-1:0] das_q, das_d;
  logic [AW-1:0] arr_q, arr_d;
  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          sample, held, emit, pop, full, push_ok;
  logic [2:0]    emit_code;

  // Sample classification and auto-repeat counters.
  always_comb begin
    last_code_d = last_code_q;
    gap_d       = gap_q;
    das_d       = das_q;
    arr_d       = arr_q;
    emit        = 1'b0;
    emit_code   = 3'(code_q - 4'd1);
    sample      = (code_q >= 4'd1) && (code_q <= 4'd8) && (code_q != prev_q);
    held        = (code_q == last_code_q) && (gap_q < HOLD_MAX);

    if (sample) begin
      gap_d = '0;
    end else if (gap_q < HOLD_MAX) begin
      gap_d = gap_q + GW'(1);
    end

    if (sample) begin
      last_code_d = code_q;
      if (!held) begin
        emit  = 1'b1;
        das_d = '0;
        arr_d = '0;
      end else if (code_q >= 4'd6) begin
        if (das_q < DAS_LAST) begin
          das_d = das_q + DW'(1);
        end else if (das_q == DAS_LAST) begin
          das_d = DAS_DONE;
          emit  = 1'b1;
          arr_d = '0;
        end else if (arr_q == ARR_LAST) begin
          emit  = 1'b1;
          arr_d = '0;
        end else begin
          arr_d = arr_q + AW'(1);
        end
      end
    end
  end

  // A push into a full FIFO is still accepted when the head pops on the same edge.
  always_comb begin
    pop     = (count_q != '0) && cmd_ready;
    full    = (count_q == FULL_CNT);
    push_ok = emit && (!full || pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (pop) rd_d = rd_q + PW'(1);
    if (push_ok) wr_d = wr_q + PW'(1);
    if (emit && !push_ok) ovf_d = 1'b1;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q      <= '0;
      prev_q      <= '0;
      last_code_q <= '0;
      gap_q       <= HOLD_MAX;
      das_q       <= '0;
      arr_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      code_q      <= button_code;
      prev_q      <= code_q;
      last_code_q <= last_code_d;
      gap_q       <= gap_d;
      das_q       <= das_d;
      arr_q       <= arr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_q] <= emit_code;
  end

  assign cmd_valid  = (count_q != '0);
  assign cmd_code   = cmd_valid ? mem_q[rd_q] : 3'd0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/input_command_queue.md
# input_command_queue

Converts the 4-bit per-frame button code from the NES input controller into a stream of one-shot game commands for the grid controller. It separates new presses from held buttons and applies delayed auto-repeat (DAS/ARR) to DOWN/LEFT/RIGHT. Commands are buffered in a small FIFO behind a valid/ready handshake. It sits between the NES input controller (upstream) and the grid controller (downstream).

## Interface
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- HOLD_WINDOW, 1000000: max clk cycles between two equal samples for them to count as one held press (20 ms at 50 MHz).
- DAS_FRAMES, 10: held samples before the first auto-repeat.
- ARR_FRAMES, 3: held samples between later auto-repeats.
- clk  in  1  50 MHz system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- button_code  in  4  upstream code: 0 none, 1 A, 2 B, 3 SELECT, 4 START, 5 UP, 6 DOWN, 7 LEFT, 8 RIGHT; 9–15 invalid.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  consumer accepts the head this cycle.
- cmd_code  out  3  command = button_code−1: 0 ROT_CW, 1 ROT_CCW, 2 PAUSE, 3 START, 4 HARD_DROP, 5 SOFT_DROP, 6 LEFT, 7 RIGHT; 0 when FIFO empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries occupied.
- overflow  out  1  sticky; set when a command is dropped because the FIFO is full; cleared only by reset.

## Operation
- Input stage: code_q <= button_code each cycle; prev_q <= code_q.
- Sample: code_q in 1..8 and code_q != prev_q. Invalid codes never sample but still load prev_q.
- gap_cnt: set to 0 on every sample, otherwise increments, saturating at HOLD_WINDOW. Width clog2(HOLD_WINDOW+1).
- Classification on a sample:
  - held = (code_q == last_code) && (gap_cnt < HOLD_WINDOW).
  - otherwise new press.
  - last_code <= code_q on every sample.
- New press: emit; das_cnt <= 0; arr_cnt <= 0.
- Held sample of a non-repeatable code (1–5): no emit; counters unchanged.
- Held sample of a repeatable code (6–8):
  - das_cnt < DAS_FRAMES−1: das_cnt++, no emit.
  - das_cnt == DAS_FRAMES−1: das_cnt <= DAS_FRAMES, emit, arr_cnt <= 0.
  - das_cnt == DAS_FRAMES: arr_cnt++; when arr_cnt reaches ARR_FRAMES−1, emit and arr_cnt <= 0.
- Emit pushes code_q−1 into the FIFO at the next edge.
- FIFO: circular buffer, rd_ptr/wr_ptr mod FIFO_DEPTH (natural wrap).
  - pop = cmd_valid && cmd_ready.
  - cmd_valid = (fifo_count != 0).
  - cmd_code = mem[rd_ptr] when non-empty, else 0.
- Boundary cases:
  - Push, no pop, not full: count+1.
  - Pop, no push: count−1.
  - Push and pop in the same cycle: count unchanged. This also holds when full, so the push is accepted.
  - Push when full without pop: entry dropped, overflow <= 1, state unchanged.
  - cmd_ready while empty: no effect; count never underflows.
- Reset values:
  - cmd_valid 0, cmd_code 0, fifo_count 0, overflow 0.
  - code_q, prev_q, last_code, das_cnt, arr_cnt, pointers: 0.
  - gap_cnt = HOLD_WINDOW, so the first sample is always a new press.
- Reset mid-operation: queued and in-flight commands are discarded; no command from before reset is ever presented afterwards.

## Timing
- Latency: button_code changes after edge T, is captured in code_q at T+1, and is pushed at T+2. cmd_valid is high from T+2 when the FIFO was empty.
- One push maximum per cycle. Upstream yields at most one sample per frame, so at most one command per frame.
- The handshake follows AXI-stream style rules:
  - cmd_code is stable while cmd_valid && !cmd_ready.
  - A pop takes effect at the edge on which cmd_valid && cmd_ready.
  - The next entry (if any) appears the following cycle.
- cmd_valid does not depend combinationally on cmd_ready.
- fifo_count and overflow are registered; they update at the same edge as push/pop.

## Test plan
- Reset, then button_code 0→1 held 5 cycles, cmd_ready=1 -> one command, cmd_code=0, cmd_valid high for exactly 1 cycle starting 2 edges after the change; fifo_count returns to 0.
- LEFT held: code 7 pulses once per 833333-cycle frame for 20 frames (0 between pulses) -> LEFT commands (cmd_code=6) on frames 1, 11, 14, 17, 20; none elsewhere.
- A held the same way for 20 frames -> exactly one cmd_code=0.
- Same code 7 twice, with a 2000000-cycle gap -> two new presses, two commands.
- cmd_ready=0 with 5 distinct presses (1,2,3,5,6) -> fifo_count=4, overflow=1, cmd_code=0; drain -> codes 0,1,2,4 in order; overflow stays 1.
- FIFO full, cmd_ready=1 on the same cycle as a push of 7 -> fifo_count stays 4, overflow unchanged, 7→6 becomes the tail. Then assert reset with 3 entries queued -> cmd_valid=0, fifo_count=0, overflow=0 next cycle.
- button_code=12 -> no command.
- Code 2 then code 3 with no 0 between -> two commands (1, 2).
